// File: rtl/stage4_instr_queue.sv
// ----------------------------------------------------------------------------
// stage4_instr_queue
//
// Purpose:
//   Decoupling FIFO between decode and execute in the 4-stage pipeline.
//   Decode pushes a decoded control packet together with its PC. Execute
//   consumes the head. The queue is first-word fall-through: the head entry is
//   read combinationally from storage, so a packet is visible on rdata/rpc in
//   the cycle after the edge that wrote it. Occupancy is held in a register,
//   and full, empty and valid_out are derived only from that register.
//
// Ports:
//   CLK           in   1        clock; all state changes on the rising edge
//   RST           in   1        synchronous, active-high reset
//   queue_wen     in   1        push request from decode
//   wdata         in   DATA_W   decoded packet to push
//   wpc           in   32       PC of the pushed instruction
//   stall_queue   in   1        hold the head; no pop this cycle
//   flush_queue   in   1        discard all entries
//   is_queue_full out  1        count == DEPTH
//   empty         out  1        count == 0
//   valid_out     out  1        head holds a valid packet (= !empty)
//   rdata         out  DATA_W   head packet; 0 when empty
//   rpc           out  32       head PC; 0 when empty
//   count         out  PTR_W+1  occupancy, 0..DEPTH
//   overflow_err  out  1        one-cycle pulse after a push attempt while full
//
// Handshake:
//   Push side: a push is accepted on an edge where queue_wen=1 and
//   is_queue_full=0, unless flush_queue is high. A push presented while full is
//   dropped. Decode must hold the packet and retry. Pop side: valid_out acts as
//   "valid" and !stall_queue acts as "ready". The head is consumed on an edge
//   where both are high, unless flush_queue is high.
// ----------------------------------------------------------------------------
module stage4_instr_queue #(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 128,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              queue_wen,
    input  logic [DATA_W-1:0] wdata,
    input  logic [31:0]       wpc,
    input  logic              stall_queue,
    input  logic              flush_queue,
    output logic              is_queue_full,
    output logic              empty,
    output logic              valid_out,
    output logic [DATA_W-1:0] rdata,
    output logic [31:0]       rpc,
    output logic [PTR_W:0]    count,
    output logic              overflow_err
);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [31:0]       pc_mem   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count_q;
    logic              overflow_q;

    logic              push;
    logic              pop;

    // Status comes only from the registered occupancy. There is no
    // combinational path from the request inputs to these flags.
    assign is_queue_full = (count_q == (PTR_W+1)'(DEPTH));
    assign empty         = (count_q == '0);
    assign valid_out     = ~empty;
    assign count         = count_q;
    assign overflow_err  = overflow_q;

    // Flush has priority over push and pop in the same cycle. A push that
    // meets a full queue is dropped, even if a pop frees a slot on that edge.
    assign push = queue_wen & ~is_queue_full & ~flush_queue;
    assign pop  = valid_out & ~stall_queue & ~flush_queue;

    // Fall-through head read. The output is forced to zero when the queue is
    // empty, so stale storage contents never reach execute.
    assign rdata = valid_out ? data_mem[rd_ptr] : '0;
    assign rpc   = valid_out ? pc_mem[rd_ptr]   : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (flush_queue) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
            overflow_q <= queue_wen & is_queue_full;
        end
    end

    // Storage is never cleared. Reset suppresses writes, so reset still takes
    // priority over a push presented on the same edge.
    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            data_mem[wr_ptr] <= wdata;
            pc_mem[wr_ptr]   <= wpc;
        end
    end

endmodule

// File: tb/tb_stage4_instr_queue.sv
// ----------------------------------------------------------------------------
// tb_stage4_instr_queue
//
// Self-checking bench for stage4_instr_queue (DEPTH=4, DATA_W=128).
// The reference model is a plain queue of {pc, data} entries. It is updated
// on each rising edge using the push, pop, flush and reset rules. A single
// compare process checks every DUT output against the model on each falling
// edge. Directed scenarios add hand-computed literal checks, and a randomized
// phase follows.
// ----------------------------------------------------------------------------
module tb_stage4_instr_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 128;
    localparam int PTR_W  = $clog2(DEPTH);

    // ---------------- clock / reset / DUT ----------------
    logic              CLK = 1'b0;
    logic              RST;
    logic              queue_wen;
    logic [DATA_W-1:0] wdata;
    logic [31:0]       wpc;
    logic              stall_queue;
    logic              flush_queue;
    logic              is_queue_full;
    logic              empty;
    logic              valid_out;
    logic [DATA_W-1:0] rdata;
    logic [31:0]       rpc;
    logic [PTR_W:0]    count;
    logic              overflow_err;

    always #5 CLK = ~CLK;

    stage4_instr_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .queue_wen    (queue_wen),
        .wdata        (wdata),
        .wpc          (wpc),
        .stall_queue  (stall_queue),
        .flush_queue  (flush_queue),
        .is_queue_full(is_queue_full),
        .empty        (empty),
        .valid_out    (valid_out),
        .rdata        (rdata),
        .rpc          (rpc),
        .count        (count),
        .overflow_err (overflow_err)
    );

    // ---------------- scoreboard ----------------
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en   = 1'b0;

    // Each entry is {pc, data}, with the head at index 0.
    logic [DATA_W+31:0] exp_q[$];
    bit                 exp_ovf = 1'b0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update from the specification rules. Inputs were settled #1 after
    // the previous edge.
    always @(posedge CLK) begin
        bit was_full;
        bit do_push;
        bit do_pop;
        if (RST || flush_queue) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            was_full = (exp_q.size() == DEPTH);
            do_push  = queue_wen && !was_full;
            do_pop   = (exp_q.size() > 0) && !stall_queue;
            exp_ovf  = queue_wen && was_full;
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({wpc, wdata});
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge CLK) begin
        logic [DATA_W+31:0] head;
        if (chk_en) begin
            head = (exp_q.size() > 0) ? exp_q[0] : '0;
            check("count",        count,         exp_q.size());
            check("empty",        empty,         exp_q.size() == 0);
            check("full",         is_queue_full, exp_q.size() == DEPTH);
            check("valid_out",    valid_out,     exp_q.size() != 0);
            check("rdata",        rdata,         head[DATA_W-1:0]);
            check("rpc",          rpc,           head[DATA_W+31:DATA_W]);
            check("overflow_err", overflow_err,  exp_ovf);
        end
    end

    // ---------------- driver ----------------
    // Apply one cycle of inputs. Return #1 after the edge that consumed them.
    task automatic cyc(input bit wen, input bit stall, input bit flush, input bit rst,
                       input logic [DATA_W-1:0] d, input logic [31:0] pc);
        queue_wen   = wen;
        stall_queue = stall;
        flush_queue = flush;
        RST         = rst;
        wdata       = d;
        wpc         = pc;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] pkt(input logic [31:0] tag);
        return {tag, ~tag, tag ^ 32'h5A5A_5A5A, tag + 32'd7};
    endfunction

    function automatic logic [DATA_W-1:0] rnd_pkt();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        queue_wen = 0; stall_queue = 0; flush_queue = 0; RST = 1;
        wdata = '0; wpc = '0;
        cyc(0, 0, 0, 1, '0, 0);
        cyc(0, 0, 0, 1, '0, 0);
        chk_en = 1'b1;
        check("reset_count_lit", count, 0);
        check("reset_empty_lit", empty, 1);

        // Reset in the middle of filling the queue.
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, pkt(32'h50 + i), 32'h50 + i);
        check("midfill_count_lit", count, 3);
        cyc(0, 0, 0, 1, '0, 0);
        cyc(1, 0, 0, 1, pkt(32'h99), 32'h99);
        check("rst_count_lit", count, 0);
        check("rst_empty_lit", empty, 1);
        check("rst_valid_lit", valid_out, 0);
        check("rst_rdata_lit", rdata, 0);

        // Fill while stalled, then drain in order.
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, pkt(32'h100 + 4*i), 32'h100 + 4*i);
        check("fill_full_lit", is_queue_full, 1);
        check("fill_head_lit", rpc, 32'h100);
        for (int i = 0; i < 4; i++) begin
            check("drain_rpc_lit", rpc, 32'h100 + 4*i);
            check("drain_rdata_lit", rdata, pkt(32'h100 + 4*i));
            cyc(0, 0, 0, 0, '0, 0);
        end
        check("drain_empty_lit", empty, 1);

        // A push while full is dropped even though a pop happens on that edge.
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, pkt(32'h200 + i), 32'h200 + i);
        cyc(1, 0, 0, 0, pkt(32'hDEAD), 32'hDEAD);
        check("ovf_pulse_lit", overflow_err, 1);
        check("ovf_count_lit", count, 3);
        check("ovf_head_lit", rpc, 32'h201);
        cyc(0, 1, 0, 0, '0, 0);
        check("ovf_clear_lit", overflow_err, 0);

        // Push and pop together at count=2 for 10 cycles; the pointers wrap.
        cyc(0, 0, 1, 0, '0, 0);
        cyc(1, 1, 0, 0, pkt(32'h300), 32'h300);
        cyc(1, 1, 0, 0, pkt(32'h301), 32'h301);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, pkt(32'h310 + i), 32'h310 + i);
        check("pp_count_lit", count, 2);
        check("pp_head_lit", rpc, 32'h318);

        // Flush wins over a concurrent push.
        cyc(1, 1, 0, 0, pkt(32'h400), 32'h400);
        check("pre_flush_count_lit", count, 3);
        cyc(1, 0, 1, 0, pkt(32'h4FF), 32'h4FF);
        check("flush_count_lit", count, 0);
        check("flush_empty_lit", empty, 1);
        check("flush_ovf_lit", overflow_err, 0);
        cyc(1, 1, 0, 0, pkt(32'h410), 32'h410);
        check("post_flush_count_lit", count, 1);
        check("post_flush_rpc_lit", rpc, 32'h410);

        // Stall holds the head while pushes continue until the queue is full.
        cyc(1, 1, 0, 0, pkt(32'h411), 32'h411);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 0, 0, pkt(32'h420 + i), 32'h420 + i);
            check("stall_rpc_lit", rpc, 32'h410);
        end
        check("stall_count_lit", count, 4);
        check("stall_rdata_lit", rdata, pkt(32'h410));

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(99) < 65, $urandom_range(99) < 35,
                $urandom_range(99) < 3, $urandom_range(199) < 1,
                rnd_pkt(), $urandom);
        end
        cyc(0, 0, 0, 0, '0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
